bsg_aes_encrypt_arbiter: RTL
============================

Name: bsg_aes_encrypt_arbiter

Overview:
- Shares one non-pipelined AES-256 encrypt engine among NUM_REQ_P requesters.
- The engine takes a 384-bit input: the top 128 bits are plaintext, the bottom 256 bits are the key. It returns a 2048-bit output: ciphertext concatenated with the 15-round key chain. Engine handshake: ready/valid on input, valid/yumi on output.
- Round-robin arbitration; exactly one transaction in flight.
- Each result is steered back to its owning requester on a per-requester valid/yumi response channel.
- Sits between client ports (DMA or CSR front-ends) and the encrypt engine.

Parameters:
- NUM_REQ_P, 4, number of requesters; legal range 1..16.
- TIMEOUT_P, 1024, maximum cycles allowed in WAIT_RES before timeout_o is set; legal range 17 or more.
- ID_W_LP (localparam), max(1, clog2(NUM_REQ_P)), width of the requester ID.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- reset_n_i  in  1  asynchronous, active-low reset.
- req_v_i  in  NUM_REQ_P  per-requester request valid.
- req_data_i  in  NUM_REQ_P*384  requester k's data is in slice [k*384 +: 384].
- req_ready_o  out  NUM_REQ_P  one-hot accept for the granted requester.
- resp_v_o  out  NUM_REQ_P  result valid, one-hot to the owner.
- resp_data_o  out  2048  result, shared by all requesters.
- resp_id_o  out  ID_W_LP  owner of the current result.
- resp_yumi_i  in  NUM_REQ_P  per-requester result consume.
- eng_data_o  out  384  engine input data.
- eng_v_o  out  1  engine input valid.
- eng_ready_i  in  1  engine input ready.
- eng_data_i  in  2048  engine output data.
- eng_v_i  in  1  engine output valid.
- eng_yumi_o  out  1  engine output consume.
- busy_o  out  1  high whenever state is not IDLE.
- txn_count_o  out  16  count of completed deliveries; wraps at 2^16.
- timeout_o  out  1  sticky timeout flag.

Behaviour:
- Reset (reset_n_i=0, effective immediately, including mid-transaction):
  - state=IDLE; rr_ptr=0; owner=0.
  - Request and result registers cleared to 0; txn_count_o=0; timeout_o=0.
  - All valid/ready/yumi outputs are 0 while reset is asserted.
- States: IDLE, ISSUE, WAIT_RES, DELIVER.
- IDLE:
  - grant = first k with req_v_i[k]=1, searching rr_ptr, rr_ptr+1, ... modulo NUM_REQ_P.
  - req_ready_o = onehot(grant) when any req_v_i is set, else 0.
  - req_ready_o may depend combinationally on req_v_i. Requesters must not make req_v_i depend on req_ready_o.
  - On a grant: latch req_data_i[grant] and owner=grant; next state ISSUE.
  - With no request, stay in IDLE.
- ISSUE:
  - eng_v_o=1; eng_data_o=latched request; the latched request holds stable until transfer.
  - On eng_v_o&eng_ready_i: clear the timeout counter; next state WAIT_RES.
- WAIT_RES:
  - eng_yumi_o=eng_v_i.
  - On eng_v_i: latch eng_data_i; next state DELIVER.
  - Timeout counter increments every cycle. On reaching TIMEOUT_P, set timeout_o (sticky until reset) and keep waiting; no recovery.
- DELIVER:
  - resp_v_o=onehot(owner); resp_data_o=latched result; resp_id_o=owner.
  - On resp_yumi_i[owner]: txn_count_o+1; rr_ptr=(owner+1) mod NUM_REQ_P; next state IDLE.
  - resp_yumi_i bits of non-owners are ignored at all times.
  - resp_yumi_i while resp_v_o=0 is ignored.
- Outputs outside their state:
  - req_ready_o, eng_v_o, eng_yumi_o and resp_v_o are 0 outside their stated states.
  - resp_data_o and resp_id_o hold their last values.
- Throughput:
  - At most one transaction in flight.
  - A new grant happens no earlier than the cycle after yumi; there is no IDLE bypass.
- Latency: with ready asserted by the engine and yumi by the requester, the cycles between req accept and resp_v_o equal the engine latency plus 3.
- Fairness: a continuously requesting client waits at most NUM_REQ_P-1 transactions.
- NUM_REQ_P=1: rr_ptr stays at 0; arbitration degenerates to a pass-through FSM.

Test Plan:
- Single request: requester 2 sends plaintext 0x00112233445566778899aabbccddeeff with key 0x000102..1f. Required response: resp_v_o=4'b0100, resp_id_o=2, resp_data_o[2047:1920]=0x8ea2b7ca516745bfeafc49904b496089, txn_count_o=1.
- All four requesters hold req_v_i=4'b1111 from reset. Required response: grant order 0,1,2,3,0; each result is routed to its own ID with the matching ciphertext.
- Back-pressure: hold resp_yumi_i=0 for 50 cycles in DELIVER. Required response: resp_v_o and resp_data_o are stable, req_ready_o=0 even with req_v_i=4'b1111, and the next grant comes only after yumi.
- Engine stall: eng_ready_i=0 for 10 cycles in ISSUE. Required response: eng_v_o stays 1 and eng_data_o is stable; the transfer happens on the first ready cycle.
- Timeout: a stub engine never asserts eng_v_i. Required response: timeout_o rises exactly TIMEOUT_P cycles after the transfer and stays at 1; busy_o=1.
- Reset mid-operation: assert reset_n_i=0 in WAIT_RES. Required response: busy_o=0, all valid outputs 0 and txn_count_o=0 immediately (asynchronous); after release, requester 0 wins first.

Source files
------------

// File: rtl/bsg_aes_encrypt_arbiter_if.sv
// ------------------------------------------------------------------------
// bsg_aes_encrypt_arbiter_if - requester and engine handshake bundle
// Revision: 1.0
// ------------------------------------------------------------------------
`default_nettype none

interface bsg_aes_encrypt_arbiter_if #(
  parameter int NUM_REQ_P = 4
);
  localparam int ID_W_LP = (NUM_REQ_P > 1) ? $clog2(NUM_REQ_P) : 1;

  logic [NUM_REQ_P-1:0]     req_v_i;
  logic [NUM_REQ_P*384-1:0] req_data_i;
  logic [NUM_REQ_P-1:0]     req_ready_o;
  logic [NUM_REQ_P-1:0]     resp_v_o;
  logic [2047:0]            resp_data_o;
  logic [ID_W_LP-1:0]       resp_id_o;
  logic [NUM_REQ_P-1:0]     resp_yumi_i;
  logic [383:0]             eng_data_o;
  logic                     eng_v_o;
  logic                     eng_ready_i;
  logic [2047:0]            eng_data_i;
  logic                     eng_v_i;
  logic                     eng_yumi_o;

  modport slave (
    input  req_v_i, req_data_i, resp_yumi_i, eng_ready_i, eng_data_i, eng_v_i,
    output req_ready_o, resp_v_o, resp_data_o, resp_id_o, eng_data_o, eng_v_o, eng_yumi_o
  );

  modport master (
    output req_v_i, req_data_i, resp_yumi_i, eng_ready_i, eng_data_i, eng_v_i,
    input  req_ready_o, resp_v_o, resp_data_o, resp_id_o, eng_data_o, eng_v_o, eng_yumi_o
  );
endinterface

`default_nettype wire

// File: rtl/bsg_aes_encrypt_arbiter.sv
// ------------------------------------------------------------------------
// bsg_aes_encrypt_arbiter - round-robin sharing of one AES-256 encrypt engine
// Revision: 1.0
// ------------------------------------------------------------------------
`default_nettype none

module bsg_aes_encrypt_arbiter #(
  parameter int NUM_REQ_P = 4,
  parameter int TIMEOUT_P = 1024
) (
  input  logic                       clk_i,
  input  logic                       reset_n_i,
  bsg_aes_encrypt_arbiter_if.slave   bus,
  output logic                       busy_o,
  output logic [15:0]                txn_count_o,
  output logic                       timeout_o
);
  localparam int ID_W_LP  = (NUM_REQ_P > 1) ? $clog2(NUM_REQ_P) : 1;
  localparam int TMO_W_LP = $clog2(TIMEOUT_P + 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE    = 2'd1,
    WAIT_RES = 2'd2,
    DELIVER  = 2'd3
  } state_e;

  state_e               r_state, w_state_next;
  logic [ID_W_LP-1:0]   r_rr_ptr, r_owner, w_grant, w_rr_next;
  logic [ID_W_LP:0]     w_idx;
  logic                 w_any;
  logic [383:0]         r_req, w_sel_data;
  logic [2047:0]        r_result;
  logic [TMO_W_LP-1:0]  r_tmo_cnt;
  logic                 r_timeout;
  logic [15:0]          r_txn_count;
  logic [NUM_REQ_P-1:0] w_owner_1h, w_grant_1h;
  logic                 w_accept, w_xfer, w_res_in, w_done;

  // Search starts at r_rr_ptr; both operands are below NUM_REQ_P so one subtract wraps.
  always_comb begin
    w_any   = 1'b0;
    w_grant = '0;
    w_idx   = '0;
    for (int i = 0; i < NUM_REQ_P; i++) begin
      w_idx = {1'b0, r_rr_ptr} + (ID_W_LP+1)'(i);
      if (w_idx >= (ID_W_LP+1)'(NUM_REQ_P))
        w_idx = w_idx - (ID_W_LP+1)'(NUM_REQ_P);
      if (!w_any && bus.req_v_i[w_idx[ID_W_LP-1:0]]) begin
        w_any   = 1'b1;
        w_grant = w_idx[ID_W_LP-1:0];
      end
    end
  end

  always_comb begin
    w_sel_data = '0;
    for (int k = 0; k < NUM_REQ_P; k++) begin
      if (w_grant == ID_W_LP'(k))
        w_sel_data = bus.req_data_i[k*384 +: 384];
    end
  end

  assign w_grant_1h = NUM_REQ_P'(1) << w_grant;
  assign w_owner_1h = NUM_REQ_P'(1) << r_owner;
  assign w_rr_next  = (r_owner == ID_W_LP'(NUM_REQ_P-1)) ? '0 : r_owner + ID_W_LP'(1);

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) r_state <= IDLE;
    else            r_state <= w_state_next;
  end

  // req_ready_o is combinational on req_v_i, so it is gated by reset as well.
  always_comb begin
    w_state_next    = r_state;
    bus.req_ready_o = '0;
    bus.eng_v_o     = 1'b0;
    bus.eng_yumi_o  = 1'b0;
    bus.resp_v_o    = '0;
    w_accept        = 1'b0;
    w_xfer          = 1'b0;
    w_res_in        = 1'b0;
    w_done          = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_any && reset_n_i) begin
          bus.req_ready_o = w_grant_1h;
          w_accept        = 1'b1;
          w_state_next    = ISSUE;
        end
      end
      ISSUE: begin
        bus.eng_v_o = 1'b1;
        if (bus.eng_ready_i) begin
          w_xfer       = 1'b1;
          w_state_next = WAIT_RES;
        end
      end
      WAIT_RES: begin
        bus.eng_yumi_o = bus.eng_v_i;
        if (bus.eng_v_i) begin
          w_res_in     = 1'b1;
          w_state_next = DELIVER;
        end
      end
      DELIVER: begin
        bus.resp_v_o = w_owner_1h;
        if (bus.resp_yumi_i[r_owner]) begin
          w_done       = 1'b1;
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_rr_ptr    <= '0;
      r_owner     <= '0;
      r_req       <= '0;
      r_result    <= '0;
      r_tmo_cnt   <= '0;
      r_timeout   <= 1'b0;
      r_txn_count <= '0;
    end else begin
      if (w_accept) begin
        r_req   <= w_sel_data;
        r_owner <= w_grant;
      end
      // Counter saturates so a long hang cannot wrap it; the flag is sticky.
      if (w_xfer)
        r_tmo_cnt <= '0;
      else if (r_state == WAIT_RES && r_tmo_cnt != TMO_W_LP'(TIMEOUT_P))
        r_tmo_cnt <= r_tmo_cnt + TMO_W_LP'(1);
      if (r_state == WAIT_RES && r_tmo_cnt == TMO_W_LP'(TIMEOUT_P-1))
        r_timeout <= 1'b1;
      if (w_res_in)
        r_result <= bus.eng_data_i;
      if (w_done) begin
        r_txn_count <= r_txn_count + 16'd1;
        r_rr_ptr    <= w_rr_next;
      end
    end
  end

  assign bus.eng_data_o  = r_req;
  assign bus.resp_data_o = r_result;
  assign bus.resp_id_o   = r_owner;
  assign busy_o          = (r_state != IDLE);
  assign txn_count_o     = r_txn_count;
  assign timeout_o       = r_timeout;

endmodule

`default_nettype wire
